// File: rtl/wb_master_pkg.sv
// wb_master_pkg: shared widths, FSM states and command/response records for wb_cmd_master.
// Contents:
//   WB_ADR_W / WB_DAT_W / WB_SEL_W  default Wishbone address, data and byte-select widths
//   state_e                         initiator FSM states IDLE, REQ, RSP
//   wb_cmd_t                        captured command {we, adr, dat, sel}
//   wb_rsp_t                        captured response {dat, err, tout}
package wb_master_pkg;
    localparam int WB_ADR_W = 5;
    localparam int WB_DAT_W = 32;
    localparam int WB_SEL_W = WB_DAT_W / 8;

    typedef enum logic [1:0] {IDLE, REQ, RSP} state_e;

    typedef struct packed {
        logic                we;
        logic [WB_ADR_W-1:0] adr;
        logic [WB_DAT_W-1:0] dat;
        logic [WB_SEL_W-1:0] sel;
    } wb_cmd_t;

    typedef struct packed {
        logic [WB_DAT_W-1:0] dat;
        logic                err;
        logic                tout;
    } wb_rsp_t;
endpackage

// File: rtl/wb_rst_gen.sv
// wb_rst_gen: turns an async active-low reset into a registered active-high slave reset.
// Ports:
//   i_clk    clock
//   i_rst_n  async active-low reset input
//   o_rst    active-high reset, set asynchronously, released on the RST_HOLD-th edge after i_rst_n rises
module wb_rst_gen #(
    parameter int RST_HOLD = 4
) (
    input  logic i_clk,
    input  logic i_rst_n,
    output logic o_rst
);
    localparam int CW = $clog2(RST_HOLD + 1);

    logic [CW-1:0] r_cnt;
    logic          r_rst;

    // r_cnt counts the remaining hold edges; the output falls on the edge that takes it from 1 to 0
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_cnt <= CW'(RST_HOLD);
            r_rst <= 1'b1;
        end else begin
            r_cnt <= (r_cnt != '0) ? r_cnt - 1'b1 : r_cnt;
            r_rst <= (r_cnt > CW'(1));
        end
    end

    assign o_rst = r_rst;
endmodule

// File: rtl/wb_cmd_master.sv
// wb_cmd_master: Wishbone classic single-cycle initiator driven by a valid/ready command port.
// Optional feature: define WB_MASTER_TIMEOUT_EN to abort a REQ phase after TOUT_CYC cycles with no ack/err.
// Ports:
//   wb_clk_i, wb_rst_n_i                      clock, async active-low reset
//   cmd_valid_i/cmd_ready_o                   command handshake
//   cmd_we_i/cmd_adr_i/cmd_dat_i/cmd_sel_i    command fields
//   rsp_valid_o/rsp_ready_i                   response handshake
//   rsp_dat_o/rsp_err_o/rsp_tout_o            response fields
//   wb_rst_o                                  sync active-high reset to the slave
//   wb_adr_o/wb_dat_o/wb_sel_o/wb_we_o/wb_stb_o/wb_cyc_o  Wishbone request
//   wb_dat_i/wb_ack_i/wb_err_i/wb_int_i       Wishbone response and interrupt
//   irq_o                                     wb_int_i delayed one cycle
//   busy_o                                    transaction in progress
module wb_cmd_master
    import wb_master_pkg::*;
#(
    parameter int ADR_W    = WB_ADR_W,
    parameter int DAT_W    = WB_DAT_W,
    parameter int RST_HOLD = 4
`ifdef WB_MASTER_TIMEOUT_EN
    ,
    parameter int TOUT_CYC = 16
`endif
) (
    input  logic               wb_clk_i,
    input  logic               wb_rst_n_i,
    input  logic               cmd_valid_i,
    output logic               cmd_ready_o,
    input  logic               cmd_we_i,
    input  logic [ADR_W-1:0]   cmd_adr_i,
    input  logic [DAT_W-1:0]   cmd_dat_i,
    input  logic [DAT_W/8-1:0] cmd_sel_i,
    output logic               rsp_valid_o,
    input  logic               rsp_ready_i,
    output logic [DAT_W-1:0]   rsp_dat_o,
    output logic               rsp_err_o,
    output logic               rsp_tout_o,
    output logic               wb_rst_o,
    output logic [ADR_W-1:0]   wb_adr_o,
    output logic [DAT_W-1:0]   wb_dat_o,
    output logic [DAT_W/8-1:0] wb_sel_o,
    output logic               wb_we_o,
    output logic               wb_stb_o,
    output logic               wb_cyc_o,
    input  logic [DAT_W-1:0]   wb_dat_i,
    input  logic               wb_ack_i,
    input  logic               wb_err_i,
    input  logic               wb_int_i,
    output logic               irq_o,
    output logic               busy_o
);
    state_e  r_state, w_state_nxt;
    wb_cmd_t r_cmd;
    wb_rsp_t r_rsp;
    logic    r_irq;
    logic    w_go, w_done, w_tout;

    wb_rst_gen #(.RST_HOLD(RST_HOLD)) u_rst_gen (
        .i_clk   (wb_clk_i),
        .i_rst_n (wb_rst_n_i),
        .o_rst   (wb_rst_o)
    );

    assign w_go   = cmd_valid_i && cmd_ready_o;
    assign w_done = (r_state == REQ) && (wb_ack_i || wb_err_i || w_tout);

`ifdef WB_MASTER_TIMEOUT_EN
    localparam int TW = $clog2(TOUT_CYC + 1);

    logic [TW-1:0] r_tcnt;

    // r_tcnt holds the number of completed REQ cycles; the last allowed cycle is TOUT_CYC-1
    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_tcnt <= '0;
        end else if (w_go) begin
            r_tcnt <= '0;
        end else if (r_state == REQ) begin
            r_tcnt <= r_tcnt + 1'b1;
        end
    end

    assign w_tout = (r_state == REQ) && (r_tcnt == TW'(TOUT_CYC - 1)) && !wb_ack_i && !wb_err_i;
`else
    assign w_tout = 1'b0;
`endif

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    w_state_nxt = w_go ? REQ : IDLE;
            REQ:     w_state_nxt = w_done ? RSP : REQ;
            RSP:     w_state_nxt = rsp_ready_i ? IDLE : RSP;
            default: w_state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge wb_clk_i or negedge wb_rst_n_i) begin
        if (!wb_rst_n_i) begin
            r_cmd <= '0;
            r_rsp <= '0;
            r_irq <= 1'b0;
        end else begin
            r_irq <= wb_int_i;
            if (w_go) begin
                r_cmd.we  <= cmd_we_i;
                r_cmd.adr <= cmd_adr_i;
                r_cmd.dat <= cmd_dat_i;
                r_cmd.sel <= cmd_sel_i;
            end
            // err beats ack; only an error-free read ack returns slave data
            if (w_done) begin
                r_rsp.dat  <= (wb_ack_i && !wb_err_i && !r_cmd.we) ? wb_dat_i : '0;
                r_rsp.err  <= wb_err_i || w_tout;
                r_rsp.tout <= w_tout;
            end
        end
    end

    // cyc/stb/we come straight from the state register so an async reset drops them at once
    assign cmd_ready_o = (r_state == IDLE) && !wb_rst_o;
    assign busy_o      = (r_state != IDLE);
    assign wb_cyc_o    = (r_state == REQ);
    assign wb_stb_o    = (r_state == REQ);
    assign wb_we_o     = (r_state == REQ) && r_cmd.we;
    assign wb_adr_o    = r_cmd.adr;
    assign wb_dat_o    = r_cmd.dat;
    assign wb_sel_o    = r_cmd.sel;
    assign rsp_valid_o = (r_state == RSP);
    assign rsp_dat_o   = r_rsp.dat;
    assign rsp_err_o   = r_rsp.err;
    assign rsp_tout_o  = r_rsp.tout;
    assign irq_o       = r_irq;
endmodule

// File: tb/tb_wb_cmd_master.sv
// tb_wb_cmd_master: randomized self-checking bench for wb_cmd_master with a transaction-level reference model.
module tb_wb_cmd_master;
    import wb_master_pkg::*;

    localparam int RST_HOLD = 4;
    localparam int TOUT_CYC = 16;
`ifdef WB_MASTER_TIMEOUT_EN
    localparam bit TOUT_EN = 1'b1;
`else
    localparam bit TOUT_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        cmd_valid = 1'b0, cmd_we = 1'b0, rsp_ready = 1'b0;
    logic [4:0]  cmd_adr = '0;
    logic [31:0] cmd_dat = '0, wb_dat_i = '0;
    logic [3:0]  cmd_sel = '0;
    logic        wb_ack_i = 1'b0, wb_err_i = 1'b0, wb_int_i = 1'b0;
    logic        cmd_ready_o, rsp_valid_o, rsp_err_o, rsp_tout_o, wb_rst_o;
    logic        wb_we_o, wb_stb_o, wb_cyc_o, irq_o, busy_o;
    logic [31:0] rsp_dat_o, wb_dat_o;
    logic [4:0]  wb_adr_o;
    logic [3:0]  wb_sel_o;

    always #5 clk = ~clk;

    wb_cmd_master dut (
        .wb_clk_i(clk), .wb_rst_n_i(rst_n),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready_o), .cmd_we_i(cmd_we),
        .cmd_adr_i(cmd_adr), .cmd_dat_i(cmd_dat), .cmd_sel_i(cmd_sel),
        .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready), .rsp_dat_o(rsp_dat_o),
        .rsp_err_o(rsp_err_o), .rsp_tout_o(rsp_tout_o), .wb_rst_o(wb_rst_o),
        .wb_adr_o(wb_adr_o), .wb_dat_o(wb_dat_o), .wb_sel_o(wb_sel_o), .wb_we_o(wb_we_o),
        .wb_stb_o(wb_stb_o), .wb_cyc_o(wb_cyc_o), .wb_dat_i(wb_dat_i), .wb_ack_i(wb_ack_i),
        .wb_err_i(wb_err_i), .wb_int_i(wb_int_i), .irq_o(irq_o), .busy_o(busy_o)
    );

    int n_chk = 0, n_pass = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    endtask

    // Reference model: where each transaction is (waiting for a slave answer, or holding a response),
    // which command it carries, and how many edges have passed since reset release.
    wb_cmd_t     m_cmd = '0;
    bit          m_req = 0, m_rsp = 0;
    int          m_wait = 0, m_hold = 0;
    logic        m_rst = 1'b1, m_err = 1'b0, m_tout = 1'b0, m_irq = 1'b0;
    logic [31:0] m_dat = '0;

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_req = 0; m_rsp = 0; m_wait = 0; m_hold = 0; m_rst = 1'b1;
            m_err = 1'b0; m_tout = 1'b0; m_irq = 1'b0; m_dat = '0; m_cmd = '0;
        end else begin
            m_irq = wb_int_i;
            if (m_rsp) begin
                m_rsp = !rsp_ready;
            end else if (m_req) begin
                m_wait++;
                if (wb_ack_i || wb_err_i || (TOUT_EN && m_wait == TOUT_CYC)) begin
                    m_req  = 0;
                    m_rsp  = 1;
                    m_err  = wb_err_i || !wb_ack_i;
                    m_tout = !wb_err_i && !wb_ack_i;
                    m_dat  = (wb_ack_i && !wb_err_i && !m_cmd.we) ? wb_dat_i : 32'h0;
                end
            end else if (cmd_valid && !m_rst) begin
                m_req = 1; m_wait = 0;
                m_cmd.we = cmd_we; m_cmd.adr = cmd_adr; m_cmd.dat = cmd_dat; m_cmd.sel = cmd_sel;
            end
            if (m_hold < RST_HOLD) m_hold++;
            m_rst = (m_hold < RST_HOLD);
        end
    end

    always @(negedge clk) begin
        chk("wb_rst", wb_rst_o, m_rst);
        chk("cmd_ready", cmd_ready_o, !m_req && !m_rsp && !m_rst);
        chk("busy", busy_o, m_req || m_rsp);
        chk("cyc", wb_cyc_o, m_req);
        chk("stb", wb_stb_o, m_req);
        chk("we", wb_we_o, m_req && m_cmd.we);
        chk("rsp_valid", rsp_valid_o, m_rsp);
        chk("irq", irq_o, m_irq);
        if (m_req) begin
            chk("adr", wb_adr_o, m_cmd.adr);
            chk("wdat", wb_dat_o, m_cmd.dat);
            chk("sel", wb_sel_o, m_cmd.sel);
        end
        if (m_rsp) begin
            chk("rsp_dat", rsp_dat_o, m_dat);
            chk("rsp_err", rsp_err_o, m_err);
            chk("rsp_tout", rsp_tout_o, m_tout);
        end
        if (!rst_n) chk("rst_zero", {wb_adr_o, wb_dat_o, wb_sel_o, rsp_dat_o, rsp_err_o, rsp_tout_o}, '0);
    end

    initial forever begin
        @(negedge clk);
        wb_int_i = 1'($urandom_range(0, 1));
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    int          ncyc, rst_hi;
    bit          rst_rdy, held_ok;
    logic        got_we, got_err, got_tout;
    logic [31:0] got_dat;

    task automatic do_reset(input int n);
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1 chk("rst_drops_cyc", {wb_cyc_o, wb_stb_o, rsp_valid_o}, 3'b000);
        repeat (n) @(posedge clk);
        #2 rst_n = 1'b1;
        rst_hi = 0; rst_rdy = 0;
        @(negedge clk);
        while (wb_rst_o && rst_hi < 20) begin
            rst_rdy |= cmd_ready_o;
            rst_hi++;
            @(negedge clk);
        end
    endtask

    task automatic send_cmd(input logic we, input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel);
        int t = 0;
        wb_ack_i = 1'b0; wb_err_i = 1'b0; rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_we = we; cmd_adr = adr; cmd_dat = dat; cmd_sel = sel;
        while (!cmd_ready_o && t < 60) begin
            @(negedge clk);
            t++;
        end
        chk("cmd_accept", cmd_ready_o, 1'b1);
        @(negedge clk);
        cmd_valid = 1'b0; cmd_we = 1'($urandom); cmd_adr = 5'($urandom); cmd_dat = $urandom; cmd_sel = 4'($urandom);
        got_we = wb_we_o;
    endtask

    // kind: 0 ack, 1 err, 2 ack+err, 3 silent slave; answer given in REQ cycle waits+1
    task automatic txn(input logic we, input logic [4:0] adr, input logic [31:0] dat, input logic [3:0] sel,
                       input int waits, input int kind, input logic [31:0] rdat, input int rdly);
        int t = 0;
        send_cmd(we, adr, dat, sel);
        ncyc = 0;
        while (!rsp_valid_o && t < 60) begin
            ncyc += int'(wb_cyc_o);
            wb_ack_i = (t == waits) && (kind == 0 || kind == 2);
            wb_err_i = (t == waits) && (kind == 1 || kind == 2);
            wb_dat_i = (t == waits) ? rdat : $urandom;
            @(negedge clk);
            t++;
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0;
        chk("rsp_arrive", rsp_valid_o, 1'b1);
        got_dat = rsp_dat_o; got_err = rsp_err_o; got_tout = rsp_tout_o;
        held_ok = 1;
        for (int i = 0; i < rdly; i++) begin
            if (rsp_dat_o !== got_dat || cmd_ready_o || !rsp_valid_o) held_ok = 0;
            @(negedge clk);
        end
        rsp_ready = 1'b1;
        @(negedge clk);
        rsp_ready = 1'b0;
    endtask

    initial begin
        // 1: reset stretch
        do_reset(3);
        chk("t1_hold_cycles", rst_hi, 4);
        chk("t1_ready_during_hold", rst_rdy, 1'b0);
        chk("t1_ready_after", cmd_ready_o, 1'b1);
        // 2: write, ack in 2nd REQ cycle
        txn(1'b1, 5'h10, 32'hA5A5_0F0F, 4'hF, 1, 0, 32'h1234_5678, 0);
        chk("t2_we", got_we, 1'b1);
        chk("t2_cyc_cycles", ncyc, 2);
        chk("t2_err", got_err, 1'b0);
        chk("t2_dat", got_dat, 32'h0);
        // 3: read after 3 waits, response held 2 cycles
        txn(1'b0, 5'h00, 32'h0, 4'hF, 3, 0, 32'hDEAD_BEEF, 2);
        chk("t3_dat", got_dat, 32'hDEAD_BEEF);
        chk("t3_cyc_cycles", ncyc, 4);
        chk("t3_held", held_ok, 1'b1);
        // 4: ack and err together
        txn(1'b0, 5'h04, 32'h0, 4'h3, 0, 2, 32'hFFFF_FFFF, 0);
        chk("t4_err", got_err, 1'b1);
        chk("t4_tout", got_tout, 1'b0);
        chk("t4_dat", got_dat, 32'h0);
        // 5: silent slave
        if (TOUT_EN) begin
            txn(1'b0, 5'h08, 32'h0, 4'hF, 0, 3, 32'h0, 1);
            chk("t5_cyc_cycles", ncyc, 16);
            chk("t5_tout", got_tout, 1'b1);
            chk("t5_err", got_err, 1'b1);
            txn(1'b0, 5'h09, 32'h0, 4'hF, 15, 0, 32'h0BAD_F00D, 0);
            chk("t5_ack_on_expiry_dat", got_dat, 32'h0BAD_F00D);
            chk("t5_ack_on_expiry_tout", got_tout, 1'b0);
        end else begin
            send_cmd(1'b0, 5'h08, 32'h0, 4'hF);
            repeat (100) @(negedge clk);
            chk("t5_cyc_still_high", wb_cyc_o, 1'b1);
            do_reset(2);
            chk("t5_rst_hold", rst_hi, 4);
        end
        // 6: reset in the middle of REQ, then a normal read
        send_cmd(1'b0, 5'h1F, 32'h0, 4'hF);
        repeat (2) @(negedge clk);
        do_reset(2);
        chk("t6_no_rsp", rsp_valid_o, 1'b0);
        txn(1'b0, 5'h1F, 32'h0, 4'hF, 1, 0, 32'hCAFE_0001, 0);
        chk("t6_read_dat", got_dat, 32'hCAFE_0001);
        // random traffic with ack/err noise between transactions
        for (int n = 0; n < 60; n++) begin
            int r, k;
            r = int'($urandom_range(0, 9));
            k = (r < 6) ? 0 : (r < 8) ? 1 : (r == 8) ? 2 : (TOUT_EN ? 3 : 0);
            txn(1'($urandom), 5'($urandom), $urandom, 4'($urandom),
                int'($urandom_range(0, TOUT_EN ? 15 : 6)), k, $urandom, int'($urandom_range(0, 3)));
            repeat ($urandom_range(0, 3)) begin
                wb_ack_i = 1'($urandom); wb_err_i = 1'($urandom);
                rsp_ready = 1'($urandom); wb_dat_i = $urandom;
                @(negedge clk);
            end
        end
        wb_ack_i = 1'b0; wb_err_i = 1'b0; rsp_ready = 1'b0;
        repeat (2) @(negedge clk);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
